// File: rtl/text_console_pkg.sv
// Shared types and constants for the text console writer: FSM state codes,
// control-code values, default geometry and the glyph type.
package text_console_pkg;

  localparam int DEF_COLS   = 100;
  localparam int DEF_ROWS   = 50;
  localparam int DEF_S_BASE = 1024;
  localparam int ADDR_W     = 13;

  typedef logic [7:0] glyph_t;

  localparam glyph_t CC_BS = 8'h08;
  localparam glyph_t CC_LF = 8'h0A;
  localparam glyph_t CC_FF = 8'h0C;
  localparam glyph_t CC_CR = 8'h0D;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_PUT        = 3'd1;
  localparam state_t ST_CLR_LINE   = 3'd2;
  localparam state_t ST_CLR_SCREEN = 3'd3;
  localparam state_t ST_CURSOR     = 3'd4;

  function automatic logic is_ctrl(input glyph_t b);
    return (b == CC_BS) || (b == CC_LF) || (b == CC_FF) || (b == CC_CR);
  endfunction

endpackage

// File: rtl/text_console_cursor.sv
// Cursor position keeper: col/row plus row_base (= row*COLS, built by adding COLS per row).
// Commands take effect on the next clk edge; offsets are combinational.
import text_console_pkg::*;

module text_console_cursor #(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS,
  parameter int AW   = ADDR_W
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_adv,
  input  logic          cmd_nl,
  input  logic          cmd_cr,
  input  logic          cmd_back,
  input  logic          cmd_home,
  output logic [AW-1:0] offset,
  output logic [AW-1:0] nl_base,
  output logic [AW-1:0] row_base,
  output logic          at_first_col,
  output logic          at_last_col
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  assign at_first_col = (col == '0);
  assign at_last_col  = (col == LAST_COL);
  assign offset       = row_base + AW'(col);
  // Base of the row a newline lands on; the bottom row wraps back to the top.
  assign nl_base      = (row == LAST_ROW) ? '0 : row_base + AW'(COLS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (cmd_home) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (cmd_nl) begin
      col      <= '0;
      row      <= (row == LAST_ROW) ? '0 : row + RW'(1);
      row_base <= nl_base;
    end else if (cmd_cr) begin
      col <= '0;
    end else if (cmd_back) begin
      col <= col - CW'(1);
    end else if (cmd_adv) begin
      col <= col + CW'(1);
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to screen-RAM writer; one registered write per cycle, printable byte = 2 cycles.
// in_ready only in IDLE; optional cursor glyph under TEXT_CONSOLE_CURSOR_EN.
import text_console_pkg::*;

module text_console_writer #(
  parameter int     COLS        = DEF_COLS,
  parameter int     ROWS        = DEF_ROWS,
  parameter int     S_BASE      = DEF_S_BASE,
  parameter glyph_t BLANK_GLYPH = 8'h20
`ifdef TEXT_CONSOLE_CURSOR_EN
  , parameter glyph_t CURSOR_GLYPH = 8'h5F
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        sig_write,
  output logic [12:0] addr,
  output logic [31:0] value,
  output logic        busy
);

  localparam int AW = ADDR_W;
  localparam logic [AW-1:0] COLS_A  = AW'(COLS);
  localparam logic [AW-1:0] CELLS_A = AW'(ROWS * COLS);
  localparam logic [AW-1:0] BASE_A  = AW'(S_BASE);
`ifdef TEXT_CONSOLE_CURSOR_EN
  localparam state_t ST_DONE = ST_CURSOR;
`else
  localparam state_t ST_DONE = ST_IDLE;
`endif

  state_t        state, state_nxt;
  glyph_t        cur_byte;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          wr_en;
  logic [AW-1:0] wr_ofs;
  glyph_t        wr_glyph;

  logic [AW-1:0] offset, nl_base, row_base;
  logic          at_first_col, at_last_col;
  logic          put_print, cmd_adv, cmd_nl, cmd_cr, cmd_back, cmd_home;

  assign put_print = (state == ST_PUT) && !is_ctrl(cur_byte);
  assign cmd_adv   = put_print && !at_last_col;
  assign cmd_nl    = (put_print && at_last_col) || ((state == ST_PUT) && (cur_byte == CC_LF));
  assign cmd_cr    = (state == ST_PUT) && (cur_byte == CC_CR);
  assign cmd_back  = (state == ST_PUT) && (cur_byte == CC_BS) && !at_first_col;
  assign cmd_home  = (state == ST_CLR_SCREEN) && (cnt == CELLS_A);

  assign in_ready = reset_n && (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  text_console_cursor #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) u_cursor (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_adv      (cmd_adv),
    .cmd_nl       (cmd_nl),
    .cmd_cr       (cmd_cr),
    .cmd_back     (cmd_back),
    .cmd_home     (cmd_home),
    .offset       (offset),
    .nl_base      (nl_base),
    .row_base     (row_base),
    .at_first_col (at_first_col),
    .at_last_col  (at_last_col)
  );

  // Each write is decided on the edge that enters the state it belongs to,
  // so the strobe is visible during that state's cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_en     = 1'b0;
    wr_ofs    = offset;
    wr_glyph  = BLANK_GLYPH;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          state_nxt = ST_PUT;
          if (!is_ctrl(in_data)) begin
            wr_en    = 1'b1;
            wr_glyph = in_data;
`ifdef TEXT_CONSOLE_CURSOR_EN
          end else if ((in_data == CC_CR) || (in_data == CC_LF) ||
                       ((in_data == CC_BS) && !at_first_col)) begin
            wr_en = 1'b1;
`else
          end else if ((in_data == CC_BS) && !at_first_col) begin
            wr_en  = 1'b1;
            wr_ofs = offset - AW'(1);
`endif
          end
        end
      end
      ST_PUT: begin
        if (cur_byte == CC_FF) begin
          wr_en     = 1'b1;
          wr_ofs    = '0;
          cnt_nxt   = AW'(1);
          state_nxt = ST_CLR_SCREEN;
        end else if (cmd_nl) begin
          wr_en     = 1'b1;
          wr_ofs    = nl_base;
          cnt_nxt   = AW'(1);
          state_nxt = ST_CLR_LINE;
        end else begin
          state_nxt = ST_DONE;
`ifdef TEXT_CONSOLE_CURSOR_EN
          wr_en    = 1'b1;
          wr_glyph = CURSOR_GLYPH;
          wr_ofs   = cmd_adv  ? offset + AW'(1) :
                     cmd_cr   ? row_base :
                     cmd_back ? offset - AW'(1) : offset;
`endif
        end
      end
      ST_CLR_LINE: begin
        if (cnt == COLS_A) begin
          state_nxt = ST_DONE;
`ifdef TEXT_CONSOLE_CURSOR_EN
          wr_en    = 1'b1;
          wr_glyph = CURSOR_GLYPH;
          wr_ofs   = row_base;
`endif
        end else begin
          wr_en   = 1'b1;
          wr_ofs  = row_base + cnt;
          cnt_nxt = cnt + AW'(1);
        end
      end
      ST_CLR_SCREEN: begin
        if (cnt == CELLS_A) begin
          state_nxt = ST_DONE;
`ifdef TEXT_CONSOLE_CURSOR_EN
          wr_en    = 1'b1;
          wr_glyph = CURSOR_GLYPH;
          wr_ofs   = '0;
`endif
        end else begin
          wr_en   = 1'b1;
          wr_ofs  = cnt;
          cnt_nxt = cnt + AW'(1);
        end
      end
`ifdef TEXT_CONSOLE_CURSOR_EN
      ST_CURSOR: state_nxt = ST_IDLE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cur_byte  <= '0;
      cnt       <= '0;
      sig_write <= 1'b0;
      addr      <= '0;
      value     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sig_write <= wr_en;
      if ((state == ST_IDLE) && in_valid)
        cur_byte <= in_data;
      if (wr_en) begin
        addr  <= BASE_A + wr_ofs;
        value <= {24'h0, wr_glyph};
      end
    end
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Character-stream front end for the text-mode video controller: accepts ASCII bytes over a valid/ready handshake and issues single-cycle screen-RAM writes (sig_write/addr/value) in the controller's write-port format.
- Maintains cursor row/column, interprets control codes, and does line wrap, wrap-to-top with line clearing, and full-screen clear.
- Sits in the CPU clock domain between a UART/CPU byte source and the video controller write port.

Parameters:
- COLS, 100, text columns per row
- ROWS, 50, text rows
- S_BASE, 1024, write-port address of screen cell (0,0); cell address = S_BASE + row*COLS + col
- BLANK_GLYPH, 8'h20, glyph written when clearing
- CURSOR_GLYPH, 8'h5F, glyph used by the optional cursor

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte available
- in_data  in  8  ASCII byte
- in_ready  out  1  block accepts byte this cycle
- sig_write  out  1  one-cycle write strobe to video controller
- addr  out  13  write address
- value  out  32  write data; {24'h0, glyph}
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE, col=0, row=0, row_base=0, sig_write=0, addr=0, value=0, in_ready=0 during reset, then 1 in IDLE; busy=0. Reset mid-clear aborts immediately; no further writes occur.
- Handshake: byte accepted on a clk edge with in_valid & in_ready. in_ready = (state==IDLE); in_data is not sampled otherwise.
- Address formed without a multiplier: row_base tracks row*COLS (+COLS per row, 0 on wrap); addr = S_BASE + row_base + col, 13 bits.
- States: IDLE, PUT, CLR_LINE, CLR_SCREEN (plus CURSOR with the option).
- Printable byte (0x20..0x7E, and all other codes not listed below):
  - IDLE -> PUT.
  - In the cycle after acceptance: sig_write=1, addr=current cell, value={24'h0, byte}.
  - Cursor advances col+1.
  - If col was COLS-1: newline rule.
- Newline rule:
  - col=0.
  - If row<ROWS-1: row+1. Else row=0, row_base=0.
  - In both cases go to CLR_LINE, which writes BLANK_GLYPH to cols 0..COLS-1 of the new row, one write per cycle (COLS cycles), then returns to IDLE.
- 0x0A LF: newline rule.
- 0x0D CR: col=0, no write, back to IDLE after one cycle.
- 0x08 BS:
  - col>0: col-1, then one blank write at the new position.
  - col==0: no-op, one cycle.
- 0x0C FF: CLR_SCREEN writes BLANK_GLYPH to all ROWS*COLS cells in ascending address order (5000 cycles at defaults), then col=row=row_base=0, IDLE.
- Throughput: a printable byte costs 2 cycles (accept + PUT). Write outputs are registered. sig_write is never high for two cells in the same cycle.
- addr/value hold their last values when sig_write=0.

Optional Feature:
- Macro: TEXT_CONSOLE_CURSOR_EN.
- Defined:
  - Before CR/LF/BS moves the cursor, write BLANK_GLYPH at the old cell (this extra cycle is skipped for a printable byte, whose write overwrites the cursor).
  - After every operation completes (including FF and CLR_LINE), state CURSOR writes CURSOR_GLYPH at the new cursor cell, then IDLE. Each operation costs +1 cycle.
- Undefined: the CURSOR state and the extra blank writes are absent; timing as above.

Decomposition:
- Package text_console_pkg holds:
  - state enum
  - control-code constants (CC_BS, CC_LF, CC_FF, CC_CR)
  - default S_BASE/COLS/ROWS localparams
  - a glyph typedef (logic [7:0])
- One sub-module, text_console_cursor: owns col/row/row_base with advance/newline/home/back commands and a computed cell offset. The top level keeps the FSM and write-port registers.

Test Plan:
- After reset, send 'A' (0x41) -> exactly one write: addr=1024, value=32'h41, one cycle after acceptance; then col=1, in_ready high again.
- 100 printable bytes from (0,0) -> last write addr=1123; then 100 blank writes at 1124..1223; cursor (1,0).
- Cursor at row 49, send LF -> 100 writes of 0x20 at addr 1024..1123; cursor (0,0); in_ready low for 100 cycles.
- Send FF -> 5000 consecutive writes 1024..6023 of value 0x20; busy low afterwards; bytes held off with in_ready=0 throughout.
- BS at col 0 -> no write. BS at col 5, row 2 -> single blank write at addr 1228.
- Assert reset_n=0 mid-FF at cell 300 -> sig_write drops immediately; after release, 'B' writes to addr 1024.
